kronos_if_prefetch: RTL

Parametrised successor of the Kronos instruction-fetch stage. Prefetches sequential instructions from a single-ported instruction memory into a DEPTH-entry buffer and presents them to ID over a valid/ready pipe. Handles ID stalls and memory misses decoupled from each other. Supports branch redirect with buffer flush and in-flight-response squash. Sits between the imem port and kronos_ID.

---
 rtl/kronos_if_prefetch.sv | 126 ++++++++++++
 1 files changed

// File: rtl/kronos_if_prefetch.sv
// Instruction prefetch stage: keeps up to DEPTH sequential fetches buffered ahead of ID,
// with one outstanding imem request and branch redirect that squashes an in-flight response.
module kronos_if_prefetch #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BOOT_ADDR = 32'h0
) (
    input  logic        clk,
    input  logic        rstz,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_data,
    output logic        instr_req,
    input  logic        instr_ack,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_ir,
    output logic        pipe_out_vld,
    input  logic        pipe_out_rdy,
    input  logic [31:0] branch_target,
    input  logic        branch
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    // Memory side
    logic          req_q,   req_d;
    logic [31:0]   addr_q,  addr_d;
    logic [31:0]   npc_q,   npc_d;
    logic          drop_q,  drop_d;

    // Buffer side
    logic [CW-1:0] count_q,  count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          vld_q,    vld_d;
    logic [31:0]   pc_buf_q [DEPTH];
    logic [31:0]   ir_buf_q [DEPTH];

    logic          resp;
    logic          push;
    logic          pop;
    logic [31:0]   tgt;
    logic [31:0]   npc_eff;
    logic          unused_tgt_lsbs;

    assign unused_tgt_lsbs = ^branch_target[1:0];

    always_comb begin
        resp    = req_q & instr_ack;
        push    = resp & ~drop_q & ~branch;
        pop     = vld_q & pipe_out_rdy;
        tgt     = {branch_target[31:2], 2'b00};
        npc_eff = branch ? tgt : npc_q;

        // A flush wins over any push/pop in the same cycle; a pop still retires the old head.
        if (branch) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            count_d  = count_q + CW'(push) - CW'(pop);
            wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
            rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        end
        vld_d = (count_d != '0);

        // Only the single outstanding response can ever be squashed, however many branches hit.
        drop_d = (drop_q & ~resp) | (branch & req_q & ~instr_ack);

        if (req_q && !instr_ack) begin
            req_d  = 1'b1;
            addr_d = addr_q;
            npc_d  = npc_eff;
        end else if (count_d < FULL) begin
            req_d  = 1'b1;
            addr_d = npc_eff;
            npc_d  = npc_eff + 32'd4;
        end else begin
            req_d  = 1'b0;
            addr_d = addr_q;
            npc_d  = npc_eff;
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            req_q    <= 1'b0;
            addr_q   <= BOOT_ADDR;
            npc_q    <= BOOT_ADDR;
            drop_q   <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            vld_q    <= 1'b0;
        end else begin
            req_q    <= req_d;
            addr_q   <= addr_d;
            npc_q    <= npc_d;
            drop_q   <= drop_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            vld_q    <= vld_d;
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_buf_q[i] <= '0;
                ir_buf_q[i] <= '0;
            end
        end else if (push) begin
            pc_buf_q[wr_ptr_q] <= addr_q;
            ir_buf_q[wr_ptr_q] <= instr_data;
        end
    end

    assign instr_req    = req_q;
    assign instr_addr   = addr_q;
    assign pipe_out_vld = vld_q;
    assign fetch_pc     = pc_buf_q[rd_ptr_q];
    assign fetch_ir     = ir_buf_q[rd_ptr_q];

endmodule
